// File: rtl/bmc_pkg.sv
// Shared types and rotation geometry for the bubble-memory field sequencer.
package bmc_pkg;

  typedef enum logic [1:0] {
    OP_ROTATE = 2'b00,
    OP_READ   = 2'b01,
    OP_WRITE  = 2'b10,
    OP_SWAP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_STOP
  } state_e;

  // One field rotation spans ROT_LEN pcen cycles; the timing generator acts at these positions.
  localparam int ROT_LEN  = 120;
  localparam int POS_W    = 7;
  localparam int GEN_POS  = 30;
  localparam int REP_POS  = 33;
  localparam int SWAP_POS = 72;

endpackage

// File: rtl/bmc_rot_counter.sv
// Position within the current field rotation, 0..ROT_LEN-1, with a clear and a boundary flag.
module bmc_rot_counter
  import bmc_pkg::*;
(
  input  logic             i_EMUCLK,
  input  logic             i_RST_n,
  input  logic             en,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             boundary
);

  assign boundary = (pos == POS_W'(ROT_LEN - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n)
      pos <= '0;
    else if (en) begin
      if (clr || boundary)
        pos <= '0;
      else
        pos <= pos + POS_W'(1);
    end
  end

endmodule

// File: rtl/bmc_field_sequencer.sv
// Controller side of the MB14506 rotation interface: one control decision per field rotation,
// sense-amp sampling for reads and bit streaming for writes.
module bmc_field_sequencer
  import bmc_pkg::*;
#(
  parameter int LENW       = 12,
  parameter int RD_LAT     = 2,
  parameter int SAMPLE_POS = 100
) (
  input  logic            i_EMUCLK,
  input  logic            i_RST_n,
  input  logic            i_CLK12M_PCEN,
  input  logic            i_CMD_VALID,
  output logic            o_CMD_READY,
  input  logic [1:0]      i_CMD_OP,
  input  logic [LENW-1:0] i_CMD_LEN,
  input  logic            i_ABORT,
  input  logic            i_WR_DATA,
  input  logic            i_WR_VALID,
  output logic            o_WR_READY,
  input  logic            i_SENSE,
  output logic            o_RD_DATA,
  output logic            o_RD_VALID,
  output logic            o_BSS_n,
  output logic            o_BSEN_n,
  output logic            o_REPEN_n,
  output logic            o_SWAPEN_n,
  output logic            o_WRDATA_n,
  output logic            o_BUSY,
  output logic            o_DONE,
  output logic            o_UNDERRUN
);

  localparam int KW = LENW + 1;  // rotation index must reach N + RD_LAT - 1

  typedef struct packed {
    state_e          state;
    op_e             op;
    logic [LENW-1:0] len;
    logic [KW-1:0]   k;
    logic            abort_pend;
    logic            stop_rot;
    logic            bss_n;
    logic            bsen_n;
    logic            repen_n;
    logic            swapen_n;
    logic            wrdata_n;
    logic            rd_data;
    logic            rd_valid;
    logic            wr_ready;
    logic            done;
    logic            underrun;
    logic            cmd_ready;
    logic            busy;
  } regs_t;

  regs_t             cur, nxt;
  logic [POS_W-1:0]  pos;
  logic              boundary;
  logic              take;
  logic              enter_rot;
  logic [KW-1:0]     enter_k;
  op_e               enter_op;
  logic [LENW-1:0]   enter_len;
  logic [KW-1:0]     last_k;

  // The accepting pcen clears the position, so the BSS cycle is position 0 of rotation 0.
  bmc_rot_counter u_rot (
    .i_EMUCLK (i_EMUCLK),
    .i_RST_n  (i_RST_n),
    .en       (i_CLK12M_PCEN),
    .clr      (take),
    .pos      (pos),
    .boundary (boundary)
  );

  always_comb begin
    if (cur.op == OP_READ)
      last_k = {1'b0, cur.len} + KW'(RD_LAT - 1);
    else
      last_k = {1'b0, cur.len} - KW'(1);
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    nxt          = cur;
    nxt.bss_n    = 1'b1;
    nxt.rd_valid = 1'b0;
    nxt.wr_ready = 1'b0;
    nxt.done     = 1'b0;
    take         = 1'b0;
    enter_rot    = 1'b0;
    enter_k      = '0;
    enter_op     = cur.op;
    enter_len    = cur.len;

    unique case (cur.state)
      ST_IDLE: begin
        if (i_CMD_VALID) begin
          take           = 1'b1;
          nxt.op         = op_e'(i_CMD_OP);
          nxt.len        = i_CMD_LEN;
          nxt.k          = '0;
          nxt.abort_pend = 1'b0;
          nxt.underrun   = 1'b0;
          if (i_CMD_LEN == '0) begin
            nxt.done = 1'b1;
          end else begin
            nxt.state  = ST_START;
            nxt.bss_n  = 1'b0;
            nxt.bsen_n = 1'b0;
            enter_rot  = 1'b1;
            enter_op   = op_e'(i_CMD_OP);
            enter_len  = i_CMD_LEN;
          end
        end
      end

      ST_START: nxt.state = ST_RUN;

      ST_RUN: begin
        if (i_ABORT)
          nxt.abort_pend = 1'b1;
        if (pos == POS_W'(SAMPLE_POS) && cur.op == OP_READ && cur.k >= KW'(RD_LAT)) begin
          nxt.rd_valid = 1'b1;
          nxt.rd_data  = i_SENSE;
        end
        if (boundary) begin
          if (cur.k == last_k || cur.abort_pend || i_ABORT) begin
            nxt.state    = ST_STOP;
            nxt.stop_rot = 1'b0;
            nxt.bsen_n   = 1'b1;
            nxt.repen_n  = 1'b1;
            nxt.swapen_n = 1'b1;
            nxt.wrdata_n = 1'b1;
          end else begin
            nxt.k     = cur.k + KW'(1);
            enter_rot = 1'b1;
            enter_k   = cur.k + KW'(1);
          end
        end
      end

      ST_STOP: begin
        // Two idle rotations let the coil pipeline drain before the next command.
        if (boundary) begin
          if (cur.stop_rot) begin
            nxt.state = ST_IDLE;
            nxt.done  = 1'b1;
          end else begin
            nxt.stop_rot = 1'b1;
          end
        end
      end

      default: nxt.state = ST_IDLE;
    endcase

    // Per-rotation controls are decided on the pcen that starts the rotation and held throughout.
    if (enter_rot) begin
      nxt.repen_n  = !(enter_op == OP_READ && enter_k < {1'b0, enter_len});
      nxt.swapen_n = !(enter_op == OP_SWAP && enter_k == '0);
      nxt.wrdata_n = 1'b1;
      if (enter_op == OP_WRITE && enter_k < {1'b0, enter_len}) begin
        nxt.wr_ready = 1'b1;
        if (i_WR_VALID)
          nxt.wrdata_n = !i_WR_DATA;
        else
          nxt.underrun = 1'b1;
      end
    end

    nxt.cmd_ready = (nxt.state == ST_IDLE);
    nxt.busy      = (nxt.state != ST_IDLE);
  end

  // NOTE: reset is synchronous and not pcen-qualified, so it abandons an operation on the next clock.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      cur           <= '0;
      cur.bss_n     <= 1'b1;
      cur.bsen_n    <= 1'b1;
      cur.repen_n   <= 1'b1;
      cur.swapen_n  <= 1'b1;
      cur.wrdata_n  <= 1'b1;
      cur.cmd_ready <= 1'b1;
    end else if (i_CLK12M_PCEN) begin
      cur <= nxt;
    end
  end

  assign o_CMD_READY = cur.cmd_ready;
  assign o_BUSY      = cur.busy;
  assign o_DONE      = cur.done;
  assign o_UNDERRUN  = cur.underrun;
  assign o_WR_READY  = cur.wr_ready;
  assign o_RD_DATA   = cur.rd_data;
  assign o_RD_VALID  = cur.rd_valid;
  assign o_BSS_n     = cur.bss_n;
  assign o_BSEN_n    = cur.bsen_n;
  assign o_REPEN_n   = cur.repen_n;
  assign o_SWAPEN_n  = cur.swapen_n;
  assign o_WRDATA_n  = cur.wrdata_n;

endmodule
